// File: rtl/store_align_unit.sv
// Store pre-processing stage: lane alignment, byte enables, region decode,
// registered DMEM/IMEM write ports, IO posted-write FIFO and misalignment tracking.
module store_align_unit #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_ADDR_W = 14,
    parameter int unsigned IO_ADDR_W  = 14,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    input  logic [31:0]                 req_addr,
    input  logic [DATA_W-1:0]           req_data,
    input  logic [2:0]                  req_size,
    input  logic [31:0]                 pc_decode,
    output logic                        stall,
    output logic [MEM_ADDR_W-1:0]       dmem_addr,
    output logic [DATA_W-1:0]           dmem_din,
    output logic [DATA_W/8-1:0]         dmem_we,
    output logic [MEM_ADDR_W-1:0]       imem_addr,
    output logic [DATA_W-1:0]           imem_din,
    output logic [DATA_W/8-1:0]         imem_we,
    output logic                        io_wr_valid,
    input  logic                        io_wr_ready,
    output logic [IO_ADDR_W-1:0]        io_wr_addr,
    output logic [DATA_W-1:0]           io_wr_data,
    output logic [DATA_W/8-1:0]         io_wr_be,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        misalign_err,
    output logic [CNT_W-1:0]            misalign_cnt,
    input  logic                        err_clr
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned LSB   = $clog2(LANES);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [IO_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]    data;
        logic [LANES-1:0]     be;
    } io_entry_t;

    // Request decode
    logic [LSB-1:0]    off;
    logic [3:0]        region;
    logic [LANES-1:0]  be_base;
    logic [LANES-1:0]  be_shift;
    logic [DATA_W-1:0] data_mask;
    logic [DATA_W-1:0] data_shift;
    logic              size_ok;
    logic              misaligned;
    logic              region_dmem;
    logic              region_imem;
    logic              region_io;
    logic              fifo_full;
    logic              accept;
    logic              wr_ok;
    logic              push;
    logic              pop;

    // State
    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_din_q, mem_din_d;
    logic [LANES-1:0]      dmem_we_q, dmem_we_d;
    logic [LANES-1:0]      imem_we_q, imem_we_d;
    io_entry_t             fifo_q [FIFO_DEPTH];
    io_entry_t             fifo_d [FIFO_DEPTH];
    io_entry_t             head_q, head_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic unused_bits;
    assign unused_bits = ^{req_addr, pc_decode};

    always_comb begin
        off        = req_addr[LSB-1:0];
        region     = req_addr[31:28];
        be_base    = '0;
        size_ok    = 1'b0;
        misaligned = 1'b0;
        case (req_size)
            3'd1: begin
                be_base = LANES'(1);
                size_ok = 1'b1;
            end
            3'd2: begin
                be_base    = LANES'(3);
                size_ok    = 1'b1;
                misaligned = off[0];
            end
            3'd3: begin
                be_base    = LANES'(15);
                size_ok    = 1'b1;
                misaligned = (off & LSB'(3)) != '0;
            end
            3'd4: begin
                if (DATA_W == 64) begin
                    be_base    = '1;
                    size_ok    = 1'b1;
                    misaligned = off != '0;
                end
            end
            default: ;
        endcase
        // Bytes outside the access size are dropped before lane placement
        data_mask = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            data_mask[8*i +: 8] = {8{be_base[i]}};
        end
        be_shift   = be_base << off;
        data_shift = (req_data & data_mask) << {off, 3'b000};

        region_dmem = (region == 4'b0001) || (region == 4'b0011);
        region_imem = (region == 4'b0011) || (region == 4'b0010);
        region_io   = (region == 4'b1000);

        fifo_full = level_q == LVL_W'(FIFO_DEPTH);
        stall     = req_valid && region_io && fifo_full;
        accept    = req_valid && !stall && size_ok;
        wr_ok     = accept && !misaligned;
        push      = wr_ok && region_io;
        pop       = valid_q && io_wr_ready;
    end

    // Next-state for memory ports, FIFO and error tracking
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        dmem_we_d  = '0;
        imem_we_d  = '0;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        if (wr_ok && (region_dmem || region_imem)) begin
            mem_addr_d = req_addr[LSB +: MEM_ADDR_W];
            mem_din_d  = data_shift;
        end
        if (wr_ok && region_dmem) begin
            dmem_we_d = be_shift;
        end
        if (wr_ok && region_imem && pc_decode[30]) begin
            imem_we_d = be_shift;
        end

        if (push) begin
            fifo_d[wr_ptr_q] = '{addr: req_addr[LSB +: IO_ADDR_W], data: data_shift, be: be_shift};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        valid_d = level_d != '0;
        head_d  = fifo_d[rd_ptr_d];

        // A misaligned store in the clear cycle wins and restarts the count at 1
        if (accept && misaligned) begin
            err_d = 1'b1;
            if (err_clr) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (err_clr) begin
            err_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            dmem_we_q  <= '0;
            imem_we_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            head_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            dmem_we_q  <= dmem_we_d;
            imem_we_q  <= imem_we_d;
            fifo_q     <= fifo_d;
            head_q     <= head_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign dmem_addr    = mem_addr_q;
    assign dmem_din     = mem_din_q;
    assign dmem_we      = dmem_we_q;
    assign imem_addr    = mem_addr_q;
    assign imem_din     = mem_din_q;
    assign imem_we      = imem_we_q;
    assign io_wr_valid  = valid_q;
    assign io_wr_addr   = head_q.addr;
    assign io_wr_data   = head_q.data;
    assign io_wr_be     = head_q.be;
    assign fifo_level   = level_q;
    assign misalign_err = err_q;
    assign misalign_cnt = cnt_q;

endmodule
